// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and widths for the data-memory arbiter
package dmem_arb_pkg;

  localparam int ADDR_W        = 32;
  localparam int SDATA_W       = 16;
  localparam int VDATA_W       = 256;
  localparam int DEF_BURST_MAX = 8;

  typedef enum logic {ARB = 1'b0, HOST_LOCK = 1'b1} arb_state_t;

  typedef enum logic {CORE = 1'b0, HOST = 1'b1} req_id_t;

  typedef struct packed {
    logic               we;
    logic               vec;
    logic [ADDR_W-1:0]  addr;
    logic [VDATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - core/host request ports and dual-port memory bus of the arbiter
interface dmem_arbiter_if import dmem_arb_pkg::*; ();

  logic               core_req, core_we, core_vec;
  logic [ADDR_W-1:0]  core_addr;
  logic [VDATA_W-1:0] core_wdata;
  logic               core_gnt, core_rvalid, core_stall;
  logic [VDATA_W-1:0] core_rdata;

  logic               host_req, host_we, host_vec, host_last;
  logic [ADDR_W-1:0]  host_addr;
  logic [VDATA_W-1:0] host_wdata;
  logic               host_gnt, host_rvalid;
  logic [VDATA_W-1:0] host_rdata;

  logic               mem_we, mem_src_sel;
  logic [ADDR_W-1:0]  mem_addr;
  logic [SDATA_W-1:0] mem_wdata_a;
  logic [VDATA_W-1:0] mem_wdata_b;
  logic [SDATA_W-1:0] mem_q_a;
  logic [VDATA_W-1:0] mem_q_b;

  modport slave (
    input  core_req, core_we, core_vec, core_addr, core_wdata,
    input  host_req, host_we, host_vec, host_last, host_addr, host_wdata,
    input  mem_q_a, mem_q_b,
    output core_gnt, core_rvalid, core_rdata, core_stall,
    output host_gnt, host_rvalid, host_rdata,
    output mem_we, mem_src_sel, mem_addr, mem_wdata_a, mem_wdata_b
  );

  modport master (
    output core_req, core_we, core_vec, core_addr, core_wdata,
    output host_req, host_we, host_vec, host_last, host_addr, host_wdata,
    output mem_q_a, mem_q_b,
    input  core_gnt, core_rvalid, core_rdata, core_stall,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_we, mem_src_sel, mem_addr, mem_wdata_a, mem_wdata_b
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - two-way round-robin pick; bit 0 = core, bit 1 = host
module rr_arb2 import dmem_arb_pkg::*; (
  input  logic [1:0] req,
  input  req_id_t    last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == HOST) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/host arbiter for the shared data memory; host burst lock under DMEM_ARB_BURST_EN
module dmem_arbiter import dmem_arb_pkg::*; #(
  parameter int unsigned BURST_MAX = DEF_BURST_MAX
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);

  logic [1:0]         pick;
  logic               lock;
  logic               core_gnt, host_gnt;
  req_id_t            last_q;
  mem_req_t           core_r, host_r, sel;
  logic               rd_valid;
  req_id_t            rd_id;
  logic               rd_vec;
  logic [VDATA_W-1:0] rd_word;

  assign core_r = '{we: bus.core_we, vec: bus.core_vec, addr: bus.core_addr, wdata: bus.core_wdata};
  assign host_r = '{we: bus.host_we, vec: bus.host_vec, addr: bus.host_addr, wdata: bus.host_wdata};

  // While the host holds a burst the core is masked out of the pick entirely.
  rr_arb2 u_rr (
    .req  ({bus.host_req, bus.core_req & ~lock}),
    .last (last_q),
    .gnt  (pick)
  );

  assign core_gnt = pick[0] & reset;
  assign host_gnt = pick[1] & reset;

  always_comb begin
    sel = '0;
    if (host_gnt)      sel = host_r;
    else if (core_gnt) sel = core_r;
  end

  assign bus.core_gnt    = core_gnt;
  assign bus.host_gnt    = host_gnt;
  assign bus.core_stall  = bus.core_req & ~core_gnt;
  assign bus.mem_we      = sel.we;
  assign bus.mem_src_sel = sel.vec;
  assign bus.mem_addr    = sel.addr;
  assign bus.mem_wdata_a = sel.wdata[SDATA_W-1:0];
  assign bus.mem_wdata_b = sel.wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q   <= HOST;
      rd_valid <= 1'b0;
      rd_id    <= CORE;
      rd_vec   <= 1'b0;
    end else begin
      if (core_gnt || host_gnt) last_q <= host_gnt ? HOST : CORE;
      rd_valid <= (core_gnt || host_gnt) && !sel.we;
      rd_id    <= host_gnt ? HOST : CORE;
      rd_vec   <= sel.vec;
    end
  end

  // The memory registers its output, so q is valid in the cycle after the grant.
  assign rd_word        = rd_vec ? bus.mem_q_b : {{(VDATA_W-SDATA_W){1'b0}}, bus.mem_q_a};
  assign bus.core_rvalid = rd_valid && (rd_id == CORE);
  assign bus.host_rvalid = rd_valid && (rd_id == HOST);
  assign bus.core_rdata  = bus.core_rvalid ? rd_word : '0;
  assign bus.host_rdata  = bus.host_rvalid ? rd_word : '0;

`ifdef DMEM_ARB_BURST_EN
  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] beat_q, beat_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      ARB: begin
        if (host_gnt && !bus.host_last) begin
          state_d = HOST_LOCK;
          beat_d  = CNT_W'(1);
        end
      end
      HOST_LOCK: begin
        if (host_gnt) begin
          if (bus.host_last || beat_q == CNT_W'(BURST_MAX - 1)) begin
            state_d = ARB;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  assign lock = (state_q == HOST_LOCK);
`else
  assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed and randomized checks of dmem_arbiter against a behavioural model
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [255:0] hmem    [logic [31:0]];
  logic [255:0] ref_mem [logic [31:0]];

  dmem_arbiter_if bus ();

  dmem_arbiter #(.BURST_MAX(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous write-first dual-port memory seen by the arbiter.
  always @(posedge clk) begin
    logic [255:0] w;
    w = hmem.exists(bus.mem_addr) ? hmem[bus.mem_addr] : '0;
    if (bus.mem_we) begin
      if (bus.mem_src_sel) w = bus.mem_wdata_b;
      else                 w[15:0] = bus.mem_wdata_a;
      hmem[bus.mem_addr] = w;
    end
    bus.mem_q_b <= w;
    bus.mem_q_a <= w[15:0];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic set_core(input logic req, input logic we, input logic vec,
                          input logic [31:0] addr, input logic [255:0] d);
    bus.core_req = req; bus.core_we = we; bus.core_vec = vec;
    bus.core_addr = addr; bus.core_wdata = d;
  endtask

  task automatic set_host(input logic req, input logic we, input logic vec, input logic last,
                          input logic [31:0] addr, input logic [255:0] d);
    bus.host_req = req; bus.host_we = we; bus.host_vec = vec; bus.host_last = last;
    bus.host_addr = addr; bus.host_wdata = d;
  endtask

  task automatic idle();
    set_core(1'b0, 1'b0, 1'b0, 32'h0, '0);
    set_host(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, '0);
  endtask

  task automatic pulse_reset();
    next_cycle();
    idle();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
  endtask

  // Core requests every cycle; host issues host_beats writes, raising last on last_beat.
  task automatic run_grants(input int n, input int host_beats, input int last_beat,
                            output string seq, output int stalls);
    int  hb;
    bit  seen_core;
    hb = 0; seen_core = 0; stalls = 0; seq = "";
    for (int c = 0; c < n; c++) begin
      next_cycle();
      set_core(1'b1, 1'b1, 1'b1, 32'h300, rand256());
      set_host(hb < host_beats, 1'b1, 1'b1, (hb + 1) == last_beat, 32'h200 + 32'(hb * 32), rand256());
      #1;
      if (bus.host_gnt)      begin seq = {seq, "H"}; hb++; end
      else if (bus.core_gnt) begin seq = {seq, "C"}; end
      else                   begin seq = {seq, "-"}; end
      if (bus.core_gnt) seen_core = 1;
      else if (!seen_core && bus.core_stall) stalls++;
    end
    next_cycle();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    set_core(1'b1, 1'b0, 1'b1, 32'h40, '0);
    set_host(1'b1, 1'b0, 1'b1, 1'b1, 32'h80, '0);
    #2;
    n_tests++;
    if ({bus.core_gnt, bus.host_gnt} !== 2'b00) begin
      n_fail++; $display("FAIL reset_gnt: got %b want 00", {bus.core_gnt, bus.host_gnt});
    end
    n_tests++;
    if ({bus.core_rvalid, bus.host_rvalid, bus.mem_we} !== 3'b000) begin
      n_fail++; $display("FAIL reset_rvalid_we: got %b want 000", {bus.core_rvalid, bus.host_rvalid, bus.mem_we});
    end
    n_tests++;
    if (bus.core_rdata !== '0 || bus.host_rdata !== '0 || bus.mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got core %h host %h addr %h want 0", bus.core_rdata, bus.host_rdata, bus.mem_addr);
    end
    next_cycle();
    next_cycle();
    idle();
    reset = 1'b1;
  endtask

  task automatic test_core_rw();
    logic [255:0] a5;
    a5 = {32{8'hA5}};
    next_cycle();
    set_core(1'b1, 1'b1, 1'b1, 32'h40, a5);
    #1;
    n_tests++;
    if ({bus.core_gnt, bus.mem_we, bus.mem_src_sel} !== 3'b111 || bus.mem_addr !== 32'h40 || bus.mem_wdata_b !== a5) begin
      n_fail++; $display("FAIL rw_write: got gnt/we/sel %b addr %h want 111 addr 40",
                         {bus.core_gnt, bus.mem_we, bus.mem_src_sel}, bus.mem_addr);
    end
    next_cycle();
    set_core(1'b1, 1'b0, 1'b1, 32'h40, '0);
    #1;
    n_tests++;
    if ({bus.core_gnt, bus.mem_we, bus.core_rvalid} !== 3'b100) begin
      n_fail++; $display("FAIL rw_read_gnt: got gnt/we/rvalid %b want 100", {bus.core_gnt, bus.mem_we, bus.core_rvalid});
    end
    next_cycle();
    idle();
    #1;
    n_tests++;
    if (bus.core_rvalid !== 1'b1 || bus.host_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL rw_rvalid: got core %b host %b want 1 0", bus.core_rvalid, bus.host_rvalid);
    end
    n_tests++;
    if (bus.core_rdata !== a5) begin
      n_fail++; $display("FAIL rw_rdata: got %h want %h", bus.core_rdata, a5);
    end
  endtask

  task automatic test_tie();
    pulse_reset();
    next_cycle();
    set_core(1'b1, 1'b0, 1'b0, 32'h40, '0);
    set_host(1'b1, 1'b0, 1'b0, 1'b1, 32'h80, '0);
    #1;
    n_tests++;
    if ({bus.core_gnt, bus.host_gnt, bus.core_stall} !== 3'b100 || bus.mem_addr !== 32'h40) begin
      n_fail++; $display("FAIL tie_first: got gnt c/h/stall %b addr %h want 100 addr 40",
                         {bus.core_gnt, bus.host_gnt, bus.core_stall}, bus.mem_addr);
    end
    next_cycle();
    set_core(1'b0, 1'b0, 1'b0, 32'h0, '0);
    #1;
    n_tests++;
    if ({bus.host_gnt, bus.core_rvalid} !== 2'b11) begin
      n_fail++; $display("FAIL tie_second: got host_gnt/core_rvalid %b want 11", {bus.host_gnt, bus.core_rvalid});
    end
    n_tests++;
    if (bus.core_rdata !== {240'h0, 16'hA5A5}) begin
      n_fail++; $display("FAIL tie_core_scalar: got %h want a5a5", bus.core_rdata);
    end
    next_cycle();
    idle();
    #1;
    n_tests++;
    if ({bus.host_rvalid, bus.core_rvalid} !== 2'b10 || bus.host_rdata[255:16] !== 240'h0) begin
      n_fail++; $display("FAIL tie_host_read: got rvalid h/c %b upper %h want 10 upper 0",
                         {bus.host_rvalid, bus.core_rvalid}, bus.host_rdata[255:16]);
    end
  endtask

  task automatic core_only_write();
    next_cycle();
    set_core(1'b1, 1'b1, 1'b1, 32'h300, rand256());
    next_cycle();
    idle();
  endtask

  task automatic test_burst4();
    string seq, exp_seq;
    int    st, exp_st, n;
    core_only_write();
`ifdef DMEM_ARB_BURST_EN
    exp_seq = "HHHHC"; exp_st = 4; n = 5;
`else
    exp_seq = "HCHCHCHC"; exp_st = 1; n = 8;
`endif
    run_grants(n, 4, 4, seq, st);
    n_tests++;
    if (seq != exp_seq) begin
      n_fail++; $display("FAIL burst4_seq: got %s want %s", seq, exp_seq);
    end
    n_tests++;
    if (st != exp_st) begin
      n_fail++; $display("FAIL burst4_stall: got %0d want %0d", st, exp_st);
    end
  endtask

  task automatic test_burst_max();
    string seq, exp_seq;
    int    st, exp_st;
`ifdef DMEM_ARB_BURST_EN
    exp_seq = "HHHHHHHHC"; exp_st = 8;
`else
    exp_seq = "HCHCHCHCH"; exp_st = 1;
`endif
    run_grants(9, 9, 0, seq, st);
    n_tests++;
    if (seq != exp_seq) begin
      n_fail++; $display("FAIL burstmax_seq: got %s want %s", seq, exp_seq);
    end
    n_tests++;
    if (st != exp_st) begin
      n_fail++; $display("FAIL burstmax_stall: got %0d want %0d", st, exp_st);
    end
  endtask

  task automatic test_reset_midburst();
    core_only_write();
    next_cycle();
    set_core(1'b1, 1'b0, 1'b0, 32'h40, '0);
    set_host(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, '0);
    #1;
    n_tests++;
    if (bus.host_gnt !== 1'b1) begin
      n_fail++; $display("FAIL mid_beat1: got host_gnt %b want 1", bus.host_gnt);
    end
    next_cycle();
    #1;
    n_tests++;
    if (bus.host_rvalid !== 1'b1) begin
      n_fail++; $display("FAIL mid_beat1_rvalid: got %b want 1", bus.host_rvalid);
    end
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if ({bus.core_gnt, bus.host_gnt, bus.core_rvalid, bus.host_rvalid} !== 4'b0000) begin
      n_fail++; $display("FAIL mid_in_reset: got %b want 0000",
                         {bus.core_gnt, bus.host_gnt, bus.core_rvalid, bus.host_rvalid});
    end
    next_cycle();
    reset = 1'b1;
    #1;
    n_tests++;
    if ({bus.core_gnt, bus.host_gnt, bus.core_rvalid, bus.host_rvalid} !== 4'b1000) begin
      n_fail++; $display("FAIL mid_after_reset: got gnt c/h rvalid c/h %b want 1000",
                         {bus.core_gnt, bus.host_gnt, bus.core_rvalid, bus.host_rvalid});
    end
    next_cycle();
    set_core(1'b0, 1'b0, 1'b0, 32'h0, '0);
    bus.host_last = 1'b1;
    #1;
    n_tests++;
    if ({bus.host_gnt, bus.core_rvalid} !== 2'b11) begin
      n_fail++; $display("FAIL mid_reissue: got host_gnt/core_rvalid %b want 11", {bus.host_gnt, bus.core_rvalid});
    end
    next_cycle();
    idle();
  endtask

  task automatic test_random();
    logic         c_act, c_we, c_vec, h_act, h_we, h_vec, h_last;
    logic [31:0]  c_addr, h_addr;
    logic [255:0] c_data, h_data;
    logic         m_last_host, m_lock;
    int           m_beats, run, max_run;
    logic         pend_v, pend_host;
    logic [255:0] pend_data, word, exp_crd, exp_hrd;
    logic         ec, eh, e_we;
    logic [31:0]  e_addr;

    pulse_reset();
    c_act = 0; h_act = 0; c_we = 0; c_vec = 0; h_we = 0; h_vec = 0;
    c_addr = 0; h_addr = 0; c_data = '0; h_data = '0;
    m_last_host = 1; m_lock = 0; m_beats = 0; pend_v = 0; pend_host = 0; pend_data = '0;
    run = 0; max_run = 0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      next_cycle();
      if (!c_act && ($urandom % 3) != 0) begin
        c_act = 1; c_we = 1'($urandom); c_vec = 1'($urandom);
        c_addr = 32'h100 + 32'(($urandom % 4) * 32); c_data = rand256();
      end
      if (!h_act && ($urandom % 3) != 0) begin
        h_act = 1; h_we = 1'($urandom); h_vec = 1'($urandom);
        h_addr = 32'h100 + 32'(($urandom % 4) * 32); h_data = rand256();
      end
      h_last = (($urandom % 4) == 0);
      set_core(c_act, c_we, c_vec, c_addr, c_data);
      set_host(h_act, h_we, h_vec, h_last, h_addr, h_data);

      if (m_lock) begin
        ec = 0; eh = h_act;
      end else if (c_act && h_act) begin
        ec = m_last_host; eh = !m_last_host;
      end else begin
        ec = c_act; eh = h_act;
      end
      e_we   = eh ? h_we : (ec ? c_we : 1'b0);
      e_addr = eh ? h_addr : (ec ? c_addr : 32'h0);
      exp_crd = (pend_v && !pend_host) ? pend_data : '0;
      exp_hrd = (pend_v && pend_host) ? pend_data : '0;

      #1;
      n_tests++;
      if ({bus.core_gnt, bus.host_gnt, bus.core_stall, bus.mem_we} !== {ec, eh, c_act & !ec, e_we}) begin
        n_fail++; $display("FAIL rnd_gnt cyc %0d: got gnt c/h stall we %b want %b", cyc,
                           {bus.core_gnt, bus.host_gnt, bus.core_stall, bus.mem_we}, {ec, eh, c_act & !ec, e_we});
      end
      n_tests++;
      if (bus.mem_addr !== e_addr) begin
        n_fail++; $display("FAIL rnd_addr cyc %0d: got %h want %h", cyc, bus.mem_addr, e_addr);
      end
      n_tests++;
      if ({bus.core_rvalid, bus.host_rvalid} !== {pend_v & !pend_host, pend_v & pend_host}) begin
        n_fail++; $display("FAIL rnd_rvalid cyc %0d: got c/h %b want %b", cyc,
                           {bus.core_rvalid, bus.host_rvalid}, {pend_v & !pend_host, pend_v & pend_host});
      end
      n_tests++;
      if (bus.core_rdata !== exp_crd || bus.host_rdata !== exp_hrd) begin
        n_fail++; $display("FAIL rnd_rdata cyc %0d: got core %h host %h want core %h host %h",
                           cyc, bus.core_rdata, bus.host_rdata, exp_crd, exp_hrd);
      end

      if (bus.core_stall) run++; else run = 0;
      if (run > max_run) max_run = run;

      pend_v = 0;
      if (ec || eh) begin
        logic         a_we, a_vec;
        logic [31:0]  a_addr;
        logic [255:0] a_data;
        a_we = eh ? h_we : c_we; a_vec = eh ? h_vec : c_vec;
        a_addr = eh ? h_addr : c_addr; a_data = eh ? h_data : c_data;
        word = ref_mem.exists(a_addr) ? ref_mem[a_addr] : '0;
        if (a_we) begin
          if (a_vec) word = a_data; else word[15:0] = a_data[15:0];
          ref_mem[a_addr] = word;
        end else begin
          pend_v = 1; pend_host = eh;
          pend_data = a_vec ? word : {240'h0, word[15:0]};
        end
        m_last_host = eh;
      end
`ifdef DMEM_ARB_BURST_EN
      if (eh) begin
        if (!m_lock) begin
          if (!h_last) begin m_lock = 1; m_beats = 1; end
        end else begin
          m_beats++;
          if (h_last || m_beats == 8) m_lock = 0;
        end
      end
`endif
      if (ec) c_act = 0;
      if (eh) h_act = 0;
    end
    next_cycle();
    idle();
`ifndef DMEM_ARB_BURST_EN
    n_tests++;
    if (max_run > 1) begin
      n_fail++; $display("FAIL rnd_stall_run: got %0d consecutive stalls want at most 1", max_run);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_core_rw();
    test_tie();
    test_burst4();
    test_burst_max();
    test_reset_midburst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the shared data memory used by the SIMD processor: the core's load/store port and a host loader port (image/DMA preload and readback). Each cycle it grants at most one request and drives the memory's scalar port A (16-bit) and vector port B (256-bit), including `src_sel`. It returns read data with fixed latency and stalls the core while the host holds the memory.

## Interface
- `ADDR_W`, 32: byte address width.
- `SDATA_W`, 16: scalar data width, memory port A.
- `VDATA_W`, 256: vector data width, memory port B.
- `BURST_MAX`, 8: maximum host beats per locked burst.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `core_req`/`host_req`  in  1  request valid; held until granted.
- `core_we`/`host_we`  in  1  1 = write, 0 = read.
- `core_vec`/`host_vec`  in  1  1 = 256-bit vector access (port B), 0 = 16-bit scalar (port A).
- `core_addr`/`host_addr`  in  ADDR_W  access address.
- `core_wdata`/`host_wdata`  in  VDATA_W  write data; scalar uses bits [15:0].
- `host_last`  in  1  final beat of a host burst.
- `core_gnt`/`host_gnt`  out  1  request accepted this cycle; combinational.
- `core_rvalid`/`host_rvalid`  out  1  read data valid; registered.
- `core_rdata`/`host_rdata`  out  VDATA_W  read data.
- `core_stall`  out  1  `core_req & ~core_gnt`.
- `mem_we`  out  1  memory write enable.
- `mem_src_sel`  out  1  granted request's `vec` bit.
- `mem_addr`  out  ADDR_W  granted address.
- `mem_wdata_a`  out  SDATA_W  granted `wdata[15:0]`.
- `mem_wdata_b`  out  VDATA_W  granted `wdata`.
- `mem_q_a`  in  SDATA_W  port A read data.
- `mem_q_b`  in  VDATA_W  port B read data.

## Operation
- FSM states: `ARB` (round-robin) and `HOST_LOCK` (host burst in progress).
- In `ARB`:
  - One requester active: it is granted.
  - Both requesting: grant goes to the requester not granted last. The `last` register resets to host, so the core wins the first tie.
- In `ARB`, a host grant with `host_last=0` moves the FSM to `HOST_LOCK` and sets the beat count to 1.
- In `HOST_LOCK`:
  - Only the host may be granted.
  - The core stalls even if the host idles a cycle.
  - Each host grant increments the beat count.
  - Return to `ARB` after a granted beat with `host_last=1` or beat count = `BURST_MAX`. `last` = host, so a waiting core wins the next cycle.
- Memory outputs:
  - Driven from the granted requester.
  - With no grant: `mem_we=0` and the other `mem_*` outputs hold 0.
- Reads:
  - A registered tag records requester and `vec`.
  - On the next cycle the tagged requester sees `rvalid=1`.
  - `rdata` = `mem_q_b` for vector reads, `{240'b0, mem_q_a}` for scalar reads.
  - The other requester's `rdata` is 0.
- Writes produce no `rvalid`.
- Read-after-write to the same address in consecutive cycles returns the new data; this relies on the memory's synchronous write-first behaviour and adds no bypass.

## Timing
- Grant latency: 0 cycles, with `gnt` in the same cycle as `req` when selected.
- Read latency: `rvalid` exactly 1 cycle after the read's grant.
- Throughput: one access per cycle, back-to-back for either requester.
- Reset (async assert, active-low):
  - FSM = `ARB`, `last` = host, beat count = 0.
  - `core_rvalid=host_rvalid=0` and both `rdata=0`.
  - Grants are combinational and forced 0 while reset is low.
- Reset mid-burst or with a read outstanding: the lock and the pending `rvalid` are dropped. Requesters must re-issue.
- `host_last=1` outside a burst: single-beat access with no lock.

## Configuration
- `DMEM_ARB_BURST_EN` defined:
  - `HOST_LOCK` state, beat counter and `host_last` handling are compiled in, as above.
- Undefined:
  - FSM reduces to `ARB` only and `host_last` is ignored.
  - Every beat is arbitrated round-robin, so the core is never stalled more than 1 consecutive cycle.

## Structure
- Package `dmem_arb_pkg` holds:
  - `arb_state_t` enum (`ARB`, `HOST_LOCK`).
  - `mem_req_t` packed struct (`we`, `vec`, `addr`, `wdata`).
  - `req_id_t` (`CORE`, `HOST`).
  - Width constants `SDATA_W`, `VDATA_W`, `ADDR_W`.
- Sub-module `rr_arb2`: combinational two-way round-robin pick from `req[1:0]` and `last`, returning a one-hot grant.
- The top instantiates it between the processor, the host port and the dual-port data memory, replacing the direct processor-to-memory wiring.

## Test plan
- Core alone:
  - Vector write of `0xA5..A5` to 0x40, then vector read of 0x40 in the following cycle.
  - Required: `core_gnt` in both cycles, and `core_rvalid` one cycle after the read's grant with `core_rdata = 0xA5..A5`.
- Simultaneous `core_req`/`host_req` out of reset, both scalar reads:
  - Core granted first and host next cycle.
  - `core_stall=1` for 0 cycles.
  - `host_rdata[255:16]=0`.
- Host burst of 4 beats (last on beat 4) with the core requesting throughout:
  - `core_stall=1` for 4 cycles, then `core_gnt` on cycle 5.
  - Without the macro, grants alternate H,C,H,C.
- Host burst with `host_last` never asserted, `BURST_MAX=8`:
  - Lock released after 8 beats.
  - Core granted on beat 9.
- Reset pulse low during beat 2 of a burst with a read outstanding:
  - `rvalid` stays 0.
  - FSM returns to `ARB`.
  - Core granted immediately after reset if requesting.
